// File: rtl/ram_sized_param_if.sv
// Memory-access bus between the control unit (master) and the data RAM (slave).
// Signals:
//   MOV       request valid               (master -> slave)
//   ReadWrite 1 = read, 0 = write          (master -> slave)
//   MS_2_0    [1:0] size, [2] sign-extend  (master -> slave)
//   DataIn    right-justified write data   (master -> slave)
//   Address   byte address                 (master -> slave)
//   MOC       one-cycle completion pulse   (slave -> master)
//   DataOut   right-justified read data    (slave -> master)
//   ERR       refusal flag, valid with MOC (slave -> master)
interface ram_sized_param_if;
  logic        MOV;
  logic        ReadWrite;
  logic [2:0]  MS_2_0;
  logic [31:0] DataIn;
  logic [31:0] Address;
  logic        MOC;
  logic [31:0] DataOut;
  logic        ERR;

  modport master (
    output MOV, ReadWrite, MS_2_0, DataIn, Address,
    input  MOC, DataOut, ERR
  );

  modport slave (
    input  MOV, ReadWrite, MS_2_0, DataIn, Address,
    output MOC, DataOut, ERR
  );
endinterface

// File: rtl/ram_sized_param.sv
// Parametrised byte-addressable big-endian data RAM with MOV/MOC handshake.
// Byte, half-word and word access; optional sign extension on reads;
// optional alignment checking; configurable wait states.
// Ports:
//   CLK  clock, all state changes on rising edge
//   RST  synchronous active-high reset (memory contents are kept)
//   bus  ram_sized_param_if.slave: MOV/ReadWrite/MS_2_0/DataIn/Address in,
//        MOC/DataOut/ERR out
module ram_sized_param #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  ram_sized_param_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_t;

  logic [7:0] mem [0:DEPTH-1];

  state_t                state;
  logic [3:0]            cnt;
  logic                  rw_q;
  logic [2:0]            ms_q;
  logic [31:0]           din_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  moc_q;
  logic                  err_q;
  logic [31:0]           dout_q;

  // Address bits above the decoded range are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^bus.Address[31:ADDR_WIDTH];

  // Consecutive byte addresses; the natural ADDR_WIDTH overflow gives wrap modulo depth.
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  assign a0 = addr_q;
  assign a1 = addr_q + ADDR_WIDTH'(1);
  assign a2 = addr_q + ADDR_WIDTH'(2);
  assign a3 = addr_q + ADDR_WIDTH'(3);

  logic [1:0] size;
  logic       misaligned;
  logic       refused;
  logic       fire;
  logic       write_en;
  assign size       = ms_q[1:0];
  assign misaligned = (size == 2'b01 && addr_q[0]) || (size == 2'b10 && addr_q[1:0] != 2'b00);
  assign refused    = (size == 2'b11) || (ALIGN_CHECK && misaligned);
  // The access happens on the edge that enters DONE so MOC and DataOut appear together.
  assign fire       = (state == BUSY) && (cnt == '0);
  assign write_en   = fire && !rw_q && !refused && !RST;

  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] rd_data;
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    rd_data = '0;
    case (size)
      2'b00:   rd_data = {{24{ms_q[2] & b0[7]}}, b0};
      2'b01:   rd_data = {{16{ms_q[2] & b0[7]}}, b0, b1};
      2'b10:   rd_data = {b0, b1, b2, b3};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (write_en) begin
      case (size)
        2'b00: mem[a0] <= din_q[7:0];
        2'b01: begin
          mem[a0] <= din_q[15:8];
          mem[a1] <= din_q[7:0];
        end
        2'b10: begin
          mem[a0] <= din_q[31:24];
          mem[a1] <= din_q[23:16];
          mem[a2] <= din_q[15:8];
          mem[a3] <= din_q[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      moc_q  <= 1'b0;
      err_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          moc_q <= 1'b0;
          err_q <= 1'b0;
          if (bus.MOV) begin
            rw_q   <= bus.ReadWrite;
            ms_q   <= bus.MS_2_0;
            din_q  <= bus.DataIn;
            addr_q <= bus.Address[ADDR_WIDTH-1:0];
            cnt    <= 4'(WAIT_STATES);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            moc_q <= 1'b1;
            err_q <= refused;
            if (rw_q && !refused) dout_q <= rd_data;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          moc_q <= 1'b0;
          err_q <= 1'b0;
          state <= bus.MOV ? HOLD : IDLE;
        end
        HOLD: begin
          if (!bus.MOV) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MOC     = moc_q;
  assign bus.ERR     = err_q;
  assign bus.DataOut = dout_q;

endmodule

// File: tb/tb_ram_sized_param.sv
// Testbench for ram_sized_param: three instances with different wait-state and
// alignment settings, a byte-level reference memory per instance, and a
// scoreboard of expected completions.
module tb_ram_sized_param;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [2:0]  mov = '0;
  logic        rw = 1'b1;
  logic [2:0]  ms = '0;
  logic [31:0] din = '0;
  logic [31:0] addr = '0;

  logic        moc  [0:2];
  logic        erro [0:2];
  logic [31:0] dout [0:2];

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  ram_sized_param_if if_a ();
  ram_sized_param_if if_b ();
  ram_sized_param_if if_c ();

  assign if_a.MOV = mov[0];
  assign if_b.MOV = mov[1];
  assign if_c.MOV = mov[2];
  assign if_a.ReadWrite = rw;  assign if_b.ReadWrite = rw;  assign if_c.ReadWrite = rw;
  assign if_a.MS_2_0 = ms;     assign if_b.MS_2_0 = ms;     assign if_c.MS_2_0 = ms;
  assign if_a.DataIn = din;    assign if_b.DataIn = din;    assign if_c.DataIn = din;
  assign if_a.Address = addr;  assign if_b.Address = addr;  assign if_c.Address = addr;
  assign moc[0] = if_a.MOC;  assign erro[0] = if_a.ERR;  assign dout[0] = if_a.DataOut;
  assign moc[1] = if_b.MOC;  assign erro[1] = if_b.ERR;  assign dout[1] = if_b.DataOut;
  assign moc[2] = if_c.MOC;  assign erro[2] = if_c.ERR;  assign dout[2] = if_c.DataOut;

  ram_sized_param #(.ADDR_WIDTH(8), .WAIT_STATES(1), .ALIGN_CHECK(1'b1))
    dut_a (.CLK(CLK), .RST(RST), .bus(if_a));
  ram_sized_param #(.ADDR_WIDTH(8), .WAIT_STATES(0), .ALIGN_CHECK(1'b0))
    dut_b (.CLK(CLK), .RST(RST), .bus(if_b));
  ram_sized_param #(.ADDR_WIDTH(8), .WAIT_STATES(3), .ALIGN_CHECK(1'b1))
    dut_c (.CLK(CLK), .RST(RST), .bus(if_c));

  int ws [0:2] = '{1, 0, 3};
  bit ac [0:2] = '{1'b1, 1'b0, 1'b1};

  logic [7:0]  mm [0:2][0:255];
  logic [31:0] last_rd [0:2];

  typedef struct {
    int          sel;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sbq [$];

  function automatic logic [7:0] peek(input int sel, input int a);
    case (sel)
      0:       return dut_a.mem[a];
      1:       return dut_b.mem[a];
      default: return dut_c.mem[a];
    endcase
  endfunction

  task automatic poke(input int sel, input int a, input logic [7:0] v);
    case (sel)
      0:       dut_a.mem[a] = v;
      1:       dut_b.mem[a] = v;
      default: dut_c.mem[a] = v;
    endcase
    mm[sel][a] = v;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1;
    mov = '0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int s = 0; s < 3; s++) last_rd[s] = '0;
  endtask

  // One request on instance sel; MOV stays high for 'hold' cycles after raising.
  task automatic do_op(input int sel, input logic r, input logic [2:0] m,
                       input logic [31:0] d, input logic [31:0] a, input int hold,
                       input string name);
    exp_t e;
    int n;
    int cyc;
    int mocs;
    bit got;
    bit err_alone;
    bit misal;
    logic [31:0] v;
    logic [1:0] sz;
    exp_t p;

    sz = m[1:0];
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    misal = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    e.sel = sel;
    e.lat = ws[sel] + 1;
    e.err = (sz == 2'b11) || (ac[sel] && misal);
    if (e.err) begin
      e.data = last_rd[sel];
    end else if (r) begin
      v = '0;
      for (int i = 0; i < n; i++) v = {v[23:0], mm[sel][(int'(a[7:0]) + i) & 255]};
      if (m[2] && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
      if (m[2] && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
      e.data = v;
      last_rd[sel] = v;
    end else begin
      for (int i = 0; i < n; i++)
        mm[sel][(int'(a[7:0]) + i) & 255] = 8'(d >> (8 * (n - 1 - i)));
      e.data = last_rd[sel];
    end
    sbq.push_back(e);

    @(negedge CLK);
    rw = r; ms = m; din = d; addr = a;
    mov[sel] = 1'b1;
    cyc = 0; mocs = 0; got = 1'b0; err_alone = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        // scramble inputs after accept: the latched request must be used
        din = $urandom;
        addr = $urandom;
        ms = 3'($urandom);
        rw = 1'($urandom);
      end
      if (cyc >= hold) mov[sel] = 1'b0;
      if (erro[sel] && !moc[sel]) err_alone = 1'b1;
      if (moc[sel]) begin
        mocs++;
        if (!got) begin
          got = 1'b1;
          p = sbq.pop_front();
          total++;
          if (dout[sel] !== p.data) begin
            bad++;
            $display("FAIL %s data: got %h want %h", name, dout[sel], p.data);
          end
          total++;
          if (erro[sel] !== p.err) begin
            bad++;
            $display("FAIL %s err: got %b want %b", name, erro[sel], p.err);
          end
          total++;
          if (cyc - 1 !== p.lat) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc - 1, p.lat);
          end
        end
      end
      if (got && cyc >= hold + 4) break;
    end
    mov[sel] = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s timeout: no MOC seen, want one", name);
      void'(sbq.pop_front());
    end else if (mocs !== 1) begin
      bad++;
      $display("FAIL %s moc_count: got %0d want 1", name, mocs);
    end
    total++;
    if (err_alone) begin
      bad++;
      $display("FAIL %s err_without_moc: got 1 want 0", name);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      total++;
      if (moc[s] !== 1'b0 || erro[s] !== 1'b0 || dout[s] !== 32'h0) begin
        bad++;
        $display("FAIL reset_state[%0d]: got moc=%b err=%b dout=%h want 0 0 00000000",
                 s, moc[s], erro[s], dout[s]);
      end
    end
  endtask

  task automatic test_word_read();
    do_op(0, 1'b1, 3'b010, 32'h0, 32'h0, 1, "word_read_0");
    do_op(0, 1'b1, 3'b110, 32'h0, 32'hFFFF_FF00, 1, "word_read_hi_addr_ignored");
  endtask

  task automatic test_sign_ext();
    do_op(0, 1'b1, 3'b100, 32'h0, 32'h0, 1, "byte_read_signed");
    do_op(0, 1'b1, 3'b000, 32'h0, 32'h0, 1, "byte_read_unsigned");
    do_op(0, 1'b1, 3'b101, 32'h0, 32'h0, 1, "half_read_signed");
    do_op(0, 1'b1, 3'b001, 32'h0, 32'h2, 1, "half_read_unsigned");
    do_op(0, 1'b1, 3'b101, 32'h0, 32'h2, 1, "half_read_signed_pos");
  endtask

  task automatic test_partial_write();
    do_op(0, 1'b0, 3'b001, 32'hABCD_8181, 32'd30, 1, "half_write_30");
    do_op(0, 1'b0, 3'b010, 32'hC000_0001, 32'd24, 1, "word_write_24");
    do_op(0, 1'b1, 3'b010, 32'h0, 32'd28, 1, "word_read_28");
    do_op(0, 1'b1, 3'b010, 32'h0, 32'd24, 1, "word_read_24");
    do_op(0, 1'b1, 3'b010, 32'h0, 32'd32, 1, "word_read_32_neighbour");
    do_op(0, 1'b0, 3'b000, 32'hFFFF_FF5A, 32'd33, 1, "byte_write_33");
    do_op(0, 1'b1, 3'b010, 32'h0, 32'd32, 1, "word_read_32_after_byte");
  endtask

  task automatic test_align();
    do_op(0, 1'b0, 3'b010, 32'h1122_3344, 32'd26, 1, "misaligned_word_write_checked");
    do_op(0, 1'b1, 3'b010, 32'h0, 32'd24, 1, "read_24_after_refused");
    do_op(0, 1'b1, 3'b010, 32'h0, 32'd28, 1, "read_28_after_refused");
    do_op(0, 1'b1, 3'b001, 32'h0, 32'd1, 1, "misaligned_half_read_checked");
    do_op(0, 1'b1, 3'b011, 32'h0, 32'd0, 1, "reserved_size");
    do_op(1, 1'b0, 3'b010, 32'h1122_3344, 32'd26, 1, "misaligned_word_write_unchecked");
    do_op(1, 1'b1, 3'b010, 32'h0, 32'd24, 1, "read_24_unchecked");
    do_op(1, 1'b1, 3'b010, 32'h0, 32'd28, 1, "read_28_unchecked");
    do_op(1, 1'b0, 3'b010, 32'hA1B2_C3D4, 32'd254, 1, "wrap_word_write");
    do_op(1, 1'b1, 3'b101, 32'h0, 32'd255, 1, "wrap_half_read");
    do_op(1, 1'b1, 3'b010, 32'h0, 32'd0, 1, "read_0_after_wrap");
    do_op(1, 1'b1, 3'b011, 32'h0, 32'd0, 1, "reserved_size_unchecked");
  endtask

  task automatic test_latency_hold();
    do_op(1, 1'b1, 3'b010, 32'h0, 32'd4, 1, "ws0_read");
    do_op(2, 1'b1, 3'b010, 32'h0, 32'd4, 1, "ws3_read");
    do_op(2, 1'b0, 3'b000, 32'h0000_0077, 32'd40, 10, "ws3_held_write");
    do_op(1, 1'b0, 3'b000, 32'h0000_0066, 32'd40, 10, "ws0_held_write");
    do_op(2, 1'b1, 3'b010, 32'h0, 32'd40, 10, "ws3_held_read");
    do_op(1, 1'b1, 3'b010, 32'h0, 32'd40, 10, "ws0_held_read");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      int s;
      s = k % 3;
      do_op(s, 1'($urandom), 3'($urandom), $urandom, 32'($urandom_range(0, 255)), 1, "random_op");
    end
  endtask

  task automatic test_reset_mid();
    int mocs;
    @(negedge CLK);
    rw = 1'b0; ms = 3'b010; din = 32'hDEAD_BEEF; addr = 32'd8;
    mov[2] = 1'b1;
    @(negedge CLK);
    mov[2] = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int s = 0; s < 3; s++) last_rd[s] = '0;
    mocs = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge CLK);
      if (moc[2]) mocs++;
    end
    total++;
    if (mocs !== 0) begin
      bad++;
      $display("FAIL reset_mid_busy moc: got %0d pulses want 0", mocs);
    end
    for (int i = 8; i < 12; i++) begin
      total++;
      if (peek(2, i) !== mm[2][i]) begin
        bad++;
        $display("FAIL reset_mid_busy mem[%0d]: got %h want %h", i, peek(2, i), mm[2][i]);
      end
    end
    total++;
    if (dout[2] !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_busy dout: got %h want 00000000", dout[2]);
    end
    // MOV coinciding with RST must not be accepted
    @(negedge CLK);
    rw = 1'b0; ms = 3'b010; din = 32'h1234_5678; addr = 32'd8;
    RST = 1'b1;
    mov[2] = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    mov[2] = 1'b0;
    mocs = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge CLK);
      if (moc[2]) mocs++;
    end
    total++;
    if (mocs !== 0) begin
      bad++;
      $display("FAIL mov_with_rst moc: got %0d pulses want 0", mocs);
    end
    do_op(2, 1'b1, 3'b010, 32'h0, 32'd8, 1, "read_8_after_reset");
    do_op(2, 1'b0, 3'b010, 32'hDEAD_BEEF, 32'd8, 1, "write_8_after_reset");
    do_op(2, 1'b1, 3'b010, 32'h0, 32'd8, 1, "read_8_after_write");
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 256; i++) poke(s, i, 8'((i * 37 + 11) & 255));
      poke(s, 0, 8'h81);
      poke(s, 1, 8'h02);
      poke(s, 2, 8'h03);
      poke(s, 3, 8'h04);
      poke(s, 28, 8'h00);
      poke(s, 29, 8'h01);
      last_rd[s] = '0;
    end
    test_reset();
    test_word_read();
    test_sign_ext();
    test_partial_write();
    test_align();
    test_latency_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
